// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-neuron datapath blocks.
//   pdu_state_t  : sequencer states of the potential decay unit
//   FP_*         : IEEE-754 single-precision field positions and constants
package snn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } pdu_state_t;

  localparam int          FP_EXP_MSB  = 30;
  localparam int          FP_EXP_LSB  = 23;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_exp_decay.sv
// Combinational power-of-two decay of an IEEE-754 single by exponent
// decrement: q = f * 2^-SHIFT with flush-to-+0 on underflow.
//   f : input float
//   q : decayed float
// Inf/NaN pass through. Results that would reach exponent 0 or below
// (including zero and denormal inputs) become +0. SHIFT=0 is identity.
module fp_exp_decay
  import snn_pkg::*;
#(
  parameter int SHIFT = 1
) (
  input  logic [31:0] f,
  output logic [31:0] q
);

  localparam logic [7:0] SHIFT_E = 8'(SHIFT);

  logic [7:0] e;

  assign e = f[FP_EXP_MSB:FP_EXP_LSB];

  always_comb begin
    q = f;
    if (SHIFT_E == 8'd0) begin
      q = f;
    end else if (e == FP_EXP_MAX) begin
      q = f;
    end else if (e <= SHIFT_E) begin
      q = FP_POS_ZERO;
    end else begin
      q = {f[31], e - SHIFT_E, f[22:0]};
    end
  end

endmodule

// File: rtl/potential_decay_unit.sv
// Per-neuron membrane-potential store and timestep sequencer.
// On each timestep_start it walks every neuron: reads the stored potential,
// decays it, presents it to the potential adder, waits for the adder result,
// writes the result back and collects the spike bit.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   timestep_start             : start a sweep (dropped while busy)
//   init_en/init_idx/init_value: direct potential write (dropped while busy)
//   decayed_potential/neuron_idx/pot_valid : request to the adder
//   final_potential/spike/result_valid     : adder response
//   spike_vector               : spikes of the last completed sweep
//   busy, done                 : sweep in progress / sweep-finished pulse
//
// Handshake: pot_valid rises with decayed_potential/neuron_idx and they stay
// stable until a cycle in which pot_valid=1 and result_valid=1; that cycle
// transfers final_potential/spike. result_valid is ignored when pot_valid=0.
module potential_decay_unit
  import snn_pkg::*;
#(
  parameter int NEURONS     = 16,
  parameter int IDX_W       = 4,
  parameter int DECAY_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               timestep_start,
  input  logic               init_en,
  input  logic [IDX_W-1:0]   init_idx,
  input  logic [31:0]        init_value,
  output logic [31:0]        decayed_potential,
  output logic [IDX_W-1:0]   neuron_idx,
  output logic               pot_valid,
  input  logic [31:0]        final_potential,
  input  logic               spike,
  input  logic               result_valid,
  output logic [NEURONS-1:0] spike_vector,
  output logic               busy,
  output logic               done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

  pdu_state_t         state;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        pot_mem [NEURONS];
  logic [31:0]        final_cap;
  logic               spike_cap;
  logic [NEURONS-1:0] working_spikes;
  logic [NEURONS-1:0] spikes_next;
  logic [31:0]        decay_out;

  fp_exp_decay #(
    .SHIFT (DECAY_SHIFT)
  ) u_decay (
    .f (pot_mem[idx]),
    .q (decay_out)
  );

  // Working spike set including the neuron being written this cycle, so the
  // final neuron's spike lands in spike_vector together with the done pulse.
  always_comb begin
    spikes_next      = working_spikes;
    spikes_next[idx] = spike_cap;
  end

  // Potential storage. An idle init write and a same-cycle timestep_start
  // both take effect on one edge; LOAD reads the array a cycle later and so
  // sees the freshly written value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NEURONS; i++) begin
        pot_mem[i] <= FP_POS_ZERO;
      end
    end else if (state == ST_IDLE && init_en) begin
      pot_mem[init_idx] <= init_value;
    end else if (state == ST_WRITE) begin
      pot_mem[idx] <= final_cap;
    end
  end

  // Sweep sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      idx               <= '0;
      final_cap         <= FP_POS_ZERO;
      spike_cap         <= 1'b0;
      working_spikes    <= '0;
      decayed_potential <= FP_POS_ZERO;
      neuron_idx        <= '0;
      pot_valid         <= 1'b0;
      spike_vector      <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (timestep_start) begin
            state          <= ST_LOAD;
            idx            <= '0;
            working_spikes <= '0;
            busy           <= 1'b1;
          end
        end

        ST_LOAD: begin
          decayed_potential <= decay_out;
          neuron_idx        <= idx;
          pot_valid         <= 1'b1;
          state             <= ST_ISSUE;
        end

        ST_ISSUE: begin
          if (result_valid) begin
            final_cap <= final_potential;
            spike_cap <= spike;
            pot_valid <= 1'b0;
            state     <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          working_spikes <= spikes_next;
          if (idx == LAST_IDX) begin
            spike_vector <= spikes_next;
            done         <= 1'b1;
            state        <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_LOAD;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state     <= ST_IDLE;
          pot_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_potential_decay_unit.sv
// Self-checking bench for potential_decay_unit (NEURONS=16, DECAY_SHIFT=1).
// The bench acts as the potential adder, keeps its own model of every
// stored potential, and checks presented values through an expected queue.
module tb_potential_decay_unit;

  localparam int NEURONS = 16;
  localparam int IDX_W   = 4;
  localparam int BUDGET  = 600;

  logic               clk;
  logic               rst_n;
  logic               timestep_start;
  logic               init_en;
  logic [IDX_W-1:0]   init_idx;
  logic [31:0]        init_value;
  logic [31:0]        decayed_potential;
  logic [IDX_W-1:0]   neuron_idx;
  logic               pot_valid;
  logic [31:0]        final_potential;
  logic               spike;
  logic               result_valid;
  logic [NEURONS-1:0] spike_vector;
  logic               busy;
  logic               done;

  int checks;
  int errors;

  logic [31:0]        exp_q [$];
  logic [31:0]        model_pot [NEURONS];
  logic [NEURONS-1:0] exp_spike_vec;
  logic [31:0]        obs_pot [NEURONS];
  int                 done_cyc;
  int                 n_done;

  potential_decay_unit #(
    .NEURONS     (NEURONS),
    .IDX_W       (IDX_W),
    .DECAY_SHIFT (1)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .timestep_start    (timestep_start),
    .init_en           (init_en),
    .init_idx          (init_idx),
    .init_value        (init_value),
    .decayed_potential (decayed_potential),
    .neuron_idx        (neuron_idx),
    .pot_valid         (pot_valid),
    .final_potential   (final_potential),
    .spike             (spike),
    .result_valid      (result_valid),
    .spike_vector      (spike_vector),
    .busy              (busy),
    .done              (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decay by a factor of 2 (exponent minus one).
  function automatic logic [31:0] decay_model(input logic [31:0] f);
    logic [7:0] e;
    e = f[30:23];
    if (e == 8'hFF) return f;
    if (e <= 8'd1) return 32'h0;
    return {f[31], e - 8'd1, f[22:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic init_write(input int i, input logic [31:0] v);
    init_en    = 1'b1;
    init_idx   = IDX_W'(i);
    init_value = v;
    @(posedge clk); #1;
    init_en    = 1'b0;
    model_pot[i] = v;
  endtask

  // Runs one sweep acting as the adder (echoes the presented value).
  // stall_idx/stall_n : hold result_valid low for stall_n ISSUE cycles
  // inj_at            : cycle at which timestep_start+init_en are pulsed
  // abort_idx         : assert reset when this neuron is presented
  task automatic run_sweep(input int stall_idx, input int stall_n,
                           input logic [NEURONS-1:0] spike_mask,
                           input int inj_at, input int abort_idx);
    int cyc;
    int nxt;
    int w;
    logic in_issue;
    logic [31:0] cur_exp;
    for (int i = 0; i < NEURONS; i++) begin
      exp_q.push_back(decay_model(model_pot[i]));
      obs_pot[i] = 32'hDEAD_BEEF;
    end
    n_done   = 0;
    done_cyc = -1;
    nxt      = 0;
    w        = 0;
    in_issue = 1'b0;
    cur_exp  = '0;
    timestep_start = 1'b1;
    @(posedge clk); #1;
    timestep_start = 1'b0;
    cyc = 1;
    while (1) begin
      timestep_start = (cyc == inj_at);
      init_en        = (cyc == inj_at);
      init_idx       = '0;
      init_value     = 32'h3F80_0000;

      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          checks++;
          if (spike_vector !== spike_mask) begin
            errors++;
            $display("FAIL spike_vector_at_done actual=%h expected=%h", spike_vector, spike_mask);
          end
          exp_spike_vec = spike_mask;
        end
      end else if (done_cyc < 0) begin
        checks++;
        if (spike_vector !== exp_spike_vec) begin
          errors++;
          $display("FAIL spike_vector_hold cyc=%0d actual=%h expected=%h", cyc, spike_vector, exp_spike_vec);
        end
      end

      checks++;
      if (busy !== ((done_cyc < 0) || (cyc == done_cyc))) begin
        errors++;
        $display("FAIL busy cyc=%0d actual=%b expected=%b", cyc, busy, ((done_cyc < 0) || (cyc == done_cyc)));
      end

      if (pot_valid) begin
        if (!in_issue) begin
          in_issue = 1'b1;
          w = 0;
          if (exp_q.size() == 0) begin
            cur_exp = 32'hDEAD_BEEF;
            errors++;
            $display("FAIL scoreboard_empty cyc=%0d actual_idx=%0d expected=none", cyc, neuron_idx);
          end else begin
            cur_exp = exp_q.pop_front();
          end
          if (nxt < NEURONS) obs_pot[nxt] = decayed_potential;
          checks++;
          if (decayed_potential !== cur_exp) begin
            errors++;
            $display("FAIL presented_value n=%0d actual=%h expected=%h", nxt, decayed_potential, cur_exp);
          end
        end else begin
          checks++;
          if (decayed_potential !== cur_exp) begin
            errors++;
            $display("FAIL stall_value_stable n=%0d actual=%h expected=%h", nxt, decayed_potential, cur_exp);
          end
        end
        checks++;
        if (neuron_idx !== IDX_W'(nxt)) begin
          errors++;
          $display("FAIL neuron_idx cyc=%0d actual=%0d expected=%0d", cyc, neuron_idx, nxt);
        end
        if (nxt == abort_idx) begin
          rst_n = 1'b0;
          break;
        end
        if (nxt == stall_idx && w < stall_n) begin
          w++;
          result_valid = 1'b0;
        end else begin
          result_valid    = 1'b1;
          final_potential = decayed_potential;
          spike           = (nxt < NEURONS) ? spike_mask[nxt] : 1'b0;
          if (nxt < NEURONS) model_pot[nxt] = cur_exp;
          in_issue = 1'b0;
          nxt++;
        end
      end else begin
        checks++;
        if (in_issue) begin
          errors++;
          $display("FAIL pot_valid_dropped cyc=%0d actual=0 expected=1", cyc);
          in_issue = 1'b0;
          nxt++;
        end
        result_valid = 1'b0;
        spike        = 1'b0;
      end

      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      if (cyc >= BUDGET) begin
        errors++;
        $display("FAIL sweep_timeout actual=%0d expected_done_by=%0d", cyc, BUDGET);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    result_valid   = 1'b0;
    spike          = 1'b0;
    timestep_start = 1'b0;
    init_en        = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (decayed_potential !== 32'h0) begin errors++; $display("FAIL reset_decayed actual=%h expected=0", decayed_potential); end
    checks++; if (neuron_idx !== '0)            begin errors++; $display("FAIL reset_neuron_idx actual=%h expected=0", neuron_idx); end
    checks++; if (pot_valid !== 1'b0)           begin errors++; $display("FAIL reset_pot_valid actual=%b expected=0", pot_valid); end
    checks++; if (spike_vector !== '0)          begin errors++; $display("FAIL reset_spike_vector actual=%h expected=0", spike_vector); end
    checks++; if (busy !== 1'b0)                begin errors++; $display("FAIL reset_busy actual=%b expected=0", busy); end
    checks++; if (done !== 1'b0)                begin errors++; $display("FAIL reset_done actual=%b expected=0", done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_decay();
    init_write(0, 32'h4287_C7AE);
    init_write(1, 32'h0080_0000);
    init_write(2, 32'h7F80_0000);
    init_write(3, 32'hC200_0000);
    run_sweep(-1, 0, '0, -1, -1);
    checks++; if (obs_pot[0] !== 32'h4207_C7AE) begin errors++; $display("FAIL decay_positive actual=%h expected=4207c7ae", obs_pot[0]); end
    checks++; if (obs_pot[1] !== 32'h0000_0000) begin errors++; $display("FAIL decay_underflow actual=%h expected=00000000", obs_pot[1]); end
    checks++; if (obs_pot[2] !== 32'h7F80_0000) begin errors++; $display("FAIL decay_inf actual=%h expected=7f800000", obs_pot[2]); end
    checks++; if (obs_pot[3] !== 32'hC180_0000) begin errors++; $display("FAIL decay_negative actual=%h expected=c1800000", obs_pot[3]); end
    checks++; if (done_cyc !== 49) begin errors++; $display("FAIL sweep_length actual=%0d expected=49", done_cyc); end
    checks++; if (n_done !== 1)    begin errors++; $display("FAIL done_count actual=%0d expected=1", n_done); end
  endtask

  task automatic test_spikes();
    run_sweep(-1, 0, 16'h8020, -1, -1);
    // Neuron 0 was written back as 4207C7AE and decays once more.
    checks++; if (obs_pot[0] !== 32'h4187_C7AE) begin errors++; $display("FAIL writeback_decay actual=%h expected=4187c7ae", obs_pot[0]); end
    checks++; if (spike_vector !== 16'h8020) begin errors++; $display("FAIL spike_vector_idle actual=%h expected=8020", spike_vector); end
    run_sweep(-1, 0, 16'h0000, -1, -1);
    checks++; if (spike_vector !== 16'h0000) begin errors++; $display("FAIL spike_vector_second actual=%h expected=0000", spike_vector); end
  endtask

  task automatic test_stall();
    run_sweep(4, 7, '0, -1, -1);
    checks++; if (done_cyc !== 56) begin errors++; $display("FAIL stall_sweep_length actual=%0d expected=56", done_cyc); end
    checks++; if (n_done !== 1)    begin errors++; $display("FAIL stall_done_count actual=%0d expected=1", n_done); end
  endtask

  task automatic test_ignored_controls();
    logic [31:0] keep0;
    run_sweep(-1, 0, '0, 10, -1);
    checks++; if (n_done !== 1)    begin errors++; $display("FAIL ignored_done_count actual=%0d expected=1", n_done); end
    checks++; if (done_cyc !== 49) begin errors++; $display("FAIL ignored_sweep_length actual=%0d expected=49", done_cyc); end
    keep0 = decay_model(model_pot[0]);
    run_sweep(-1, 0, '0, -1, -1);
    checks++; if (obs_pot[0] !== keep0) begin errors++; $display("FAIL ignored_init actual=%h expected=%h", obs_pot[0], keep0); end
  endtask

  task automatic test_reset_mid_sweep();
    init_write(9, 32'h4000_0000);
    run_sweep(-1, 0, '0, -1, 8);
    #1;
    checks++; if (decayed_potential !== 32'h0) begin errors++; $display("FAIL midreset_decayed actual=%h expected=0", decayed_potential); end
    checks++; if (neuron_idx !== '0)            begin errors++; $display("FAIL midreset_neuron_idx actual=%h expected=0", neuron_idx); end
    checks++; if (pot_valid !== 1'b0)           begin errors++; $display("FAIL midreset_pot_valid actual=%b expected=0", pot_valid); end
    checks++; if (busy !== 1'b0)                begin errors++; $display("FAIL midreset_busy actual=%b expected=0", busy); end
    checks++; if (done !== 1'b0)                begin errors++; $display("FAIL midreset_done actual=%b expected=0", done); end
    checks++; if (spike_vector !== '0)          begin errors++; $display("FAIL midreset_spike_vector actual=%h expected=0", spike_vector); end
    exp_q.delete();
    for (int i = 0; i < NEURONS; i++) model_pot[i] = 32'h0;
    exp_spike_vec = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_sweep(-1, 0, '0, -1, -1);
    for (int i = 0; i < NEURONS; i++) begin
      checks++;
      if (obs_pot[i] !== 32'h0) begin
        errors++;
        $display("FAIL post_reset_zero n=%0d actual=%h expected=00000000", i, obs_pot[i]);
      end
    end
    checks++; if (done_cyc !== 49) begin errors++; $display("FAIL post_reset_length actual=%0d expected=49", done_cyc); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    timestep_start  = 1'b0;
    init_en         = 1'b0;
    init_idx        = '0;
    init_value      = '0;
    final_potential = '0;
    spike           = 1'b0;
    result_valid    = 1'b0;
    exp_spike_vec   = '0;
    for (int i = 0; i < NEURONS; i++) model_pot[i] = 32'h0;

    test_reset();
    test_decay();
    test_spikes();
    test_stall();
    test_ignored_controls();
    test_reset_mid_sweep();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/potential_decay_unit.md
Name: potential_decay_unit

Overview:
Per-neuron membrane-potential store and timestep sequencer. It is the other end of the potential adder's decayed_potential/final_potential interface. Each timestep it reads every stored neuron potential, applies floating-point decay, and presents the decayed value to the potential adder. It then writes back the adder's final_potential and collects the spike bits into a spike vector for the NoC injection logic.

Parameters:
NEURONS, 16, number of neurons held (power of two, 2..256)
IDX_W, 4, neuron index width, equals log2(NEURONS)
DECAY_SHIFT, 1, exponent decrement per timestep (decay factor 2^-DECAY_SHIFT); 0 means no decay

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
timestep_start  in  1  one-cycle pulse that starts a sweep over all neurons
init_en  in  1  write init_value into potential[init_idx]; honoured only when idle
init_idx  in  IDX_W  neuron index for the init write
init_value  in  32  IEEE-754 single potential for the init write
decayed_potential  out  32  decayed potential presented to the adder
neuron_idx  out  IDX_W  neuron currently presented
pot_valid  out  1  decayed_potential/neuron_idx valid; held until result accepted
final_potential  in  32  adder result for neuron_idx
spike  in  1  adder spike for neuron_idx
result_valid  in  1  final_potential/spike valid; sampled only while pot_valid=1
spike_vector  out  NEURONS  spikes of the last completed timestep, bit i = neuron i
busy  out  1  sweep in progress
done  out  1  one-cycle pulse when the sweep finishes and spike_vector updates

Behaviour:
- Reset, asynchronous, rst_n=0:
  - All potentials become +0 (32'h0); working spike register cleared.
  - Outputs: decayed_potential=0, neuron_idx=0, pot_valid=0, spike_vector=0, busy=0, done=0. FSM goes to IDLE.
  - Reset mid-sweep abandons the sweep; there is no partial writeback.
- FSM states: IDLE, LOAD, ISSUE, WRITE, DONE.
  - IDLE: busy=0. init_en writes potential[init_idx]. timestep_start -> LOAD with idx=0 and working spikes cleared. If init_en and timestep_start arrive together, the init write happens first and the sweep then sees the new value.
  - LOAD: register decay(potential[idx]) into decayed_potential and set neuron_idx=idx -> ISSUE.
  - ISSUE: pot_valid=1. Wait an unbounded number of cycles for result_valid. When result_valid=1, capture final_potential and spike -> WRITE.
  - WRITE: pot_valid=0. potential[idx] <= captured final_potential; working_spikes[idx] <= spike. If idx==NEURONS-1 -> DONE, else idx+1 -> LOAD.
  - DONE: spike_vector <= working_spikes; done=1 for exactly this cycle -> IDLE.
- Latency: minimum 3 cycles per neuron (result_valid in the first ISSUE cycle). A sweep takes 3*NEURONS+1 cycles from timestep_start to done; done is asserted on the last of those cycles.
- busy=1 in every state except IDLE.
- Ignored inputs:
  - timestep_start while busy is dropped, not queued.
  - init_en while busy is dropped.
  - result_valid outside ISSUE is ignored.
- Decay function, combinational on a 32-bit float f, with e=f[30:23]:
  - e==255 (Inf/NaN): pass f through unchanged.
  - e<=DECAY_SHIFT (includes zero and denormals): output +0.
  - Otherwise: output {f[31], e-DECAY_SHIFT, f[22:0]}; sign and mantissa are preserved.
  - DECAY_SHIFT=0: identity.
- spike_vector holds its value between DONE pulses. It does not change during a sweep.

Decomposition:
- Package snn_pkg:
  - FSM state typedef.
  - FP field constants: FP_EXP_MSB=30, FP_EXP_LSB=23, FP_EXP_MAX=8'hFF, FP_POS_ZERO=32'h0.
- Sub-module fp_exp_decay: combinational, parameter SHIFT, 32-bit in, 32-bit out. Reused by the later QLIF/Izhikevich decay paths.
- Potential storage: reg array of NEURONS x 32 inside the top level; no RAM macro.

Test Plan:
1. Decay, positive value: init potential[0]=32'h4287C7AE, adder echoes its input with spike=0, one sweep -> decayed_potential for neuron 0 = 32'h4207C7AE; potential[0] after the sweep = 32'h4207C7AE; done after 49 cycles (NEURONS=16).
2. Boundary decay values:
   - potential[1]=32'h00800000 -> presented as 32'h00000000.
   - potential[2]=32'h7F800000 -> presented unchanged.
   - potential[3]=32'hC2000000 -> presented as 32'hC1800000.
3. Spike collection: adder returns spike=1 for neurons 5 and 15 only -> at the done pulse spike_vector=16'h8020; it stays 16'h8020 through the next sweep until that sweep's done.
4. Handshake stall: hold result_valid=0 for 7 cycles on neuron 4 -> pot_valid, neuron_idx=4 and decayed_potential stay stable; the write occurs only after result_valid; sweep length grows by exactly 7 cycles.
5. Ignored controls: during a sweep, pulse timestep_start and init_en (idx 0, value 32'h3F800000) -> no restart, potential[0] unchanged, single done pulse.
6. Reset mid-sweep: deassert rst_n at neuron 8 -> all outputs 0 immediately, busy=0; a new sweep presents 32'h00000000 for every neuron.
